// File: rtl/bunch_strobe_sequencer.sv
// Purpose: timing master for the bunch integrator; frames of strobes, then valid, then clear.
// Latency: first strobe 1+start_dly cycles after accepted trig; int_valid 2, dac_cond 3 after last strobe.
// Backpressure: none; trig outside IDLE is dropped and flagged with a one-cycle overrun pulse.
//
// Ports: clk_i/rst_n_i (sync active-low reset), trig_i frame request, start_dly_i/samp_len_i/
//   bunch_sep_i/nb_i/sel_cfg_i frame config (latched at accept), abort_i frame abort;
//   bunch_strb_o integrate enable, dac_cond_o accumulator clear, sel_o mux select,
//   int_valid_o sums-final pulse, busy_o frame in progress, overrun_o dropped trig,
//   frame_cnt_o completed-frame count.
// Build option: define STRB_ABORT_EN to let abort_i cut a frame short straight into CLEAR.
`timescale 1ns/1ps
module bunch_strobe_sequencer #(
   parameter int DLY_W = 7,
   parameter int LEN_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             trig_i,
   input  logic [DLY_W-1:0] start_dly_i,
   input  logic [LEN_W-1:0] samp_len_i,
   input  logic [DLY_W-1:0] bunch_sep_i,
   input  logic [1:0]       nb_i,
   input  logic [1:0]       sel_cfg_i,
   input  logic             abort_i,
   output logic             bunch_strb_o,
   output logic             dac_cond_o,
   output logic [1:0]       sel_o,
   output logic             int_valid_o,
   output logic             busy_o,
   output logic             overrun_o,
   output logic [CNT_W-1:0] frame_cnt_o
);

   localparam int CW = (DLY_W > LEN_W) ? DLY_W : LEN_W;

   typedef enum logic [2:0] {
      S_IDLE, S_DELAY, S_STROBE, S_GAP, S_SETTLE, S_VALID, S_CLEAR
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       bunch_q;
   logic [LEN_W-1:0] len_q;
   logic [DLY_W-1:0] sep_q;
   logic [1:0]       nb_q;
   logic             flush_q;    // set by reset: CLEAR must show one dac_cond before IDLE
   logic             bunch_strb_q, dac_cond_q, int_valid_q, busy_q, overrun_q;
   logic [1:0]       sel_q;
   logic [CNT_W-1:0] frame_cnt_q;
   logic             abort_hit;

   // Counters run down to 0, so load length-1; a zero length behaves as one cycle.
   function automatic logic [CW-1:0] len_ld(input logic [LEN_W-1:0] l);
      return (l == '0) ? '0 : CW'(l) - CW'(1);
   endfunction

   function automatic logic [CW-1:0] sep_ld(input logic [DLY_W-1:0] s);
      return (s == '0) ? '0 : CW'(s) - CW'(1);
   endfunction

`ifdef STRB_ABORT_EN
   assign abort_hit = abort_i && (state_q != S_IDLE) && (state_q != S_CLEAR);
`else
   logic unused_abort;
   assign unused_abort = abort_i;
   assign abort_hit    = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q      <= S_CLEAR;
         flush_q      <= 1'b1;
         cnt_q        <= '0;
         bunch_q      <= '0;
         len_q        <= '0;
         sep_q        <= '0;
         nb_q         <= '0;
         bunch_strb_q <= 1'b0;
         dac_cond_q   <= 1'b0;
         int_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         sel_q        <= '0;
         frame_cnt_q  <= '0;
      end else begin
         overrun_q   <= trig_i && (state_q != S_IDLE);
         int_valid_q <= 1'b0;
         dac_cond_q  <= 1'b0;
         if (abort_hit) begin
            state_q      <= S_CLEAR;
            flush_q      <= 1'b0;
            bunch_strb_q <= 1'b0;
            dac_cond_q   <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (trig_i) begin
                     sel_q   <= sel_cfg_i;
                     len_q   <= samp_len_i;
                     sep_q   <= bunch_sep_i;
                     nb_q    <= nb_i;
                     bunch_q <= '0;
                     busy_q  <= 1'b1;
                     if (start_dly_i == '0) begin
                        state_q      <= S_STROBE;
                        bunch_strb_q <= 1'b1;
                        cnt_q        <= len_ld(samp_len_i);
                     end else begin
                        state_q <= S_DELAY;
                        cnt_q   <= CW'(start_dly_i) - CW'(1);
                     end
                  end
               end
               S_DELAY, S_GAP: begin
                  if (cnt_q == '0) begin
                     state_q      <= S_STROBE;
                     bunch_strb_q <= 1'b1;
                     cnt_q        <= len_ld(len_q);
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
               S_STROBE: begin
                  if (cnt_q == '0) begin
                     bunch_strb_q <= 1'b0;
                     if (bunch_q == nb_q) begin
                        state_q <= S_SETTLE;   // no gap after the last bunch
                     end else begin
                        state_q <= S_GAP;
                        bunch_q <= bunch_q + 2'd1;
                        cnt_q   <= sep_ld(sep_q);
                     end
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
               // One idle cycle lets the integrator register its last addition.
               S_SETTLE: begin
                  state_q     <= S_VALID;
                  int_valid_q <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
               end
               S_VALID: begin
                  state_q    <= S_CLEAR;
                  dac_cond_q <= 1'b1;
               end
               S_CLEAR: begin
                  if (flush_q) begin
                     flush_q    <= 1'b0;
                     dac_cond_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= S_CLEAR;
            endcase
         end
      end
   end

   assign bunch_strb_o = bunch_strb_q;
   assign dac_cond_o   = dac_cond_q;
   assign sel_o        = sel_q;
   assign int_valid_o  = int_valid_q;
   assign busy_o       = busy_q;
   assign overrun_o    = overrun_q;
   assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_bunch_strobe_sequencer.sv
// Purpose: self-checking bench for bunch_strobe_sequencer using frame vectors and reset/abort sequences.
// Latency: expected outputs for cycle c+1 are queued while cycle c stimulus is driven.
// Backpressure: not applicable; stimulus is fixed-length per frame.
`timescale 1ns/1ps
module tb_bunch_strobe_sequencer;
   localparam int DLY_W = 7;
   localparam int LEN_W = 5;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n, trig, abort;
   logic [DLY_W-1:0] start_dly, bunch_sep;
   logic [LEN_W-1:0] samp_len;
   logic [1:0]       nb, sel_cfg;
   logic             bunch_strb, dac_cond, int_valid, busy, overrun;
   logic [1:0]       sel;
   logic [CNT_W-1:0] frame_cnt;

   always #5 clk = ~clk;

   bunch_strobe_sequencer #(.DLY_W(DLY_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .trig_i(trig), .start_dly_i(start_dly),
      .samp_len_i(samp_len), .bunch_sep_i(bunch_sep), .nb_i(nb), .sel_cfg_i(sel_cfg),
      .abort_i(abort), .bunch_strb_o(bunch_strb), .dac_cond_o(dac_cond), .sel_o(sel),
      .int_valid_o(int_valid), .busy_o(busy), .overrun_o(overrun), .frame_cnt_o(frame_cnt)
   );

   typedef struct packed {
      logic        strb;
      logic        dac;
      logic        iv;
      logic        busy;
      logic        ovr;
      logic [1:0]  sel;
      logic [15:0] fcnt;
   } out_t;

   // One frame: config, strobe cycles as a bitmask over cycle index, int_valid cycle,
   // optional retrigger cycle and abort cycle (0 = none).
   typedef struct {
      int          dly, len, sep, nb, sel;
      logic [31:0] mask;
      int          iv, retrig, abrt;
      string       name;
   } vec_t;

   out_t        sb_q[$];
   out_t        act;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] fb;
   logic [1:0]  ps;
   vec_t        vecs[8];

   assign act = {bunch_strb, dac_cond, int_valid, busy, overrun, sel, frame_cnt};

   function automatic out_t exp_at(input vec_t v, input int c, input logic [15:0] base,
                                   input logic [1:0] psel);
      out_t e;
      e      = '0;
      e.sel  = (c >= 1) ? 2'(v.sel) : psel;
      e.fcnt = base;
      if (c >= 1 && c <= v.iv + 1) begin
         e.busy = 1'b1;
         e.strb = v.mask[c];
         e.iv   = (c == v.iv);
         e.dac  = (c == v.iv + 1);
      end
      if (c >= v.iv) e.fcnt = base + 16'd1;
      e.ovr = (v.retrig != 0) && (c == v.retrig + 1);
`ifdef STRB_ABORT_EN
      if (v.abrt != 0 && c > v.abrt) begin
         e.strb = 1'b0;
         e.iv   = 1'b0;
         e.fcnt = base;
         e.busy = (c == v.abrt + 1);
         e.dac  = (c == v.abrt + 1);
      end
`endif
      return e;
   endfunction

   task automatic step(input logic t, input logic r, input logic a, input out_t e,
                       input string nm, input int c);
      out_t want;
      trig  = t;
      rst_n = r;
      abort = a;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      want = sb_q.pop_front();
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s cyc%0d: got strb=%b dac=%b iv=%b busy=%b ovr=%b sel=%0d fcnt=%0d, need strb=%b dac=%b iv=%b busy=%b ovr=%b sel=%0d fcnt=%0d",
                  nm, c, act.strb, act.dac, act.iv, act.busy, act.ovr, act.sel, act.fcnt,
                  want.strb, want.dac, want.iv, want.busy, want.ovr, want.sel, want.fcnt);
      end
   endtask

   task automatic drive_cfg(input vec_t v, input int c);
      if (c == 0) begin
         start_dly = DLY_W'(v.dly);
         samp_len  = LEN_W'(v.len);
         bunch_sep = DLY_W'(v.sep);
         nb        = 2'(v.nb);
         sel_cfg   = 2'(v.sel);
      end else begin
         // Scramble config after accept: the frame must ignore it.
         start_dly = DLY_W'($urandom_range(0, 127));
         samp_len  = LEN_W'($urandom_range(0, 31));
         bunch_sep = DLY_W'($urandom_range(0, 127));
         nb        = 2'($urandom_range(0, 3));
         sel_cfg   = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic run_vec(input vec_t v);
      for (int c = 0; c <= v.iv + 2; c++) begin
         drive_cfg(v, c);
         step((c == 0) || (v.retrig != 0 && c == v.retrig), 1'b1,
              (v.abrt != 0) && (c == v.abrt), exp_at(v, c + 1, fb, ps), v.name, c + 1);
      end
`ifdef STRB_ABORT_EN
      if (v.abrt == 0) fb = fb + 16'd1;
`else
      fb = fb + 16'd1;
`endif
      ps = 2'(v.sel);
   endtask

   initial begin
      out_t z, d;
      z = '0;
      d = '0;
      d.dac = 1'b1;

      vecs[0] = '{3, 4, 5, 0, 2, 32'h0000_00F0,  9, 0, 0, "t1_single"};
      vecs[1] = '{0, 2, 3, 2, 1, 32'h0000_18C6, 14, 0, 0, "t2_three_bunch"};
      vecs[2] = '{3, 4, 5, 0, 3, 32'h0000_00F0,  9, 5, 0, "t3_retrig_strobe"};
      vecs[3] = '{0, 0, 0, 1, 0, 32'h0000_000A,  5, 0, 0, "t4_zero_len_sep"};
      vecs[4] = '{0, 1, 1, 3, 1, 32'h0000_00AA,  9, 0, 0, "t4b_four_bunch"};
      vecs[5] = '{1, 3, 2, 1, 2, 32'h0000_039C, 11, 0, 0, "mix_dly1"};
      vecs[6] = '{0, 0, 0, 1, 3, 32'h0000_000A,  5, 6, 0, "retrig_in_clear"};
      vecs[7] = '{3, 4, 5, 0, 1, 32'h0000_00F0,  9, 0, 5, "t6_abort"};

      drive_cfg(vecs[0], 0);
      // Power-on reset: outputs zero while held, then one dac_cond flush cycle.
      step(1'b1, 1'b0, 1'b0, z, "reset_hold", 1);
      step(1'b0, 1'b0, 1'b0, z, "reset_hold", 2);
      step(1'b0, 1'b1, 1'b0, d, "reset_flush", 3);
      step(1'b0, 1'b1, 1'b0, z, "reset_idle", 4);

      fb = '0;
      ps = '0;
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset for two cycles while strobing (cycles 5,6 held): zeros, then flush, then a clean frame.
      for (int c = 0; c <= 4; c++) begin
         drive_cfg(vecs[0], c);
         step(c == 0, 1'b1, 1'b0, exp_at(vecs[0], c + 1, fb, ps), "t5_pre_reset", c + 1);
      end
      step(1'b0, 1'b0, 1'b0, z, "t5_reset_hold", 6);
      step(1'b0, 1'b0, 1'b0, z, "t5_reset_hold", 7);
      step(1'b0, 1'b1, 1'b0, d, "t5_reset_flush", 8);
      step(1'b0, 1'b1, 1'b0, z, "t5_reset_idle", 9);
      fb = '0;
      ps = '0;
      run_vec(vecs[3]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
